// File: rtl/i2c_cmd_fifo_pkg.sv
// Shared types for the camera command queue: field widths and the packed command entry.
package i2c_cmd_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int COMP_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] saddr;
    logic [DATA_W-1:0] sdata;
    logic              rgb;
    logic [COMP_W-1:0] compression;
    logic              trigger;
  } i2c_cmd_t;

  localparam int CMD_W = $bits(i2c_cmd_t);

endpackage

// File: rtl/i2c_cmd_fifo_if.sv
// Command-queue bus: producer handshake, consumer handshake, and queue status/control.
interface i2c_cmd_fifo_if import i2c_cmd_pkg::*; #(parameter int DEPTH = 8);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] in_saddr;
  logic [DATA_W-1:0] in_sdata;
  logic              in_rgb;
  logic [COMP_W-1:0] in_compression;
  logic              in_trigger;
  logic              in_valid;
  logic              in_ready;

  logic [ADDR_W-1:0] out_saddr;
  logic [DATA_W-1:0] out_sdata;
  logic              out_rgb;
  logic [COMP_W-1:0] out_compression;
  logic              out_trigger;
  logic              out_valid;
  logic              out_ready;

  logic              flush;
  logic              clr_overflow;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_saddr, in_sdata, in_rgb, in_compression, in_trigger, in_valid,
    output out_ready, flush, clr_overflow,
    input  in_ready, out_saddr, out_sdata, out_rgb, out_compression, out_trigger,
    input  out_valid, overflow, count
  );

  modport slave (
    input  in_saddr, in_sdata, in_rgb, in_compression, in_trigger, in_valid,
    input  out_ready, flush, clr_overflow,
    output in_ready, out_saddr, out_sdata, out_rgb, out_compression, out_trigger,
    output out_valid, overflow, count
  );

endinterface

// File: rtl/i2c_cmd_fifo_ctrl.sv
// Queue bookkeeping: read/write pointers, occupancy, full/empty, sticky overflow and flush.
module i2c_cmd_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             clr_overflow,
  output logic             push_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop_en;
  logic             drop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == {CNT_W{1'b0}});
  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  // Handshake qualification and next-state for pointers, count and overflow.
  always_comb begin
    push_en    = in_valid && !full && !flush;
    pop_en     = out_ready && !empty && !flush;
    drop       = in_valid && full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A dropped write beats a same-cycle clear; flush leaves the flag alone.
    if (!flush && drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/i2c_cmd_fifo.sv
// First-word-fall-through camera command queue; owns the entry storage and field pack/unpack.
module i2c_cmd_fifo import i2c_cmd_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  i2c_cmd_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  i2c_cmd_t         mem_q [DEPTH];
  i2c_cmd_t         mem_d [DEPTH];
  i2c_cmd_t         in_cmd_s;
  i2c_cmd_t         head_s;
  logic             push_en_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;
  logic             overflow_s;

  i2c_cmd_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (bus.in_valid),
    .out_ready    (bus.out_ready),
    .flush        (bus.flush),
    .clr_overflow (bus.clr_overflow),
    .push_en      (push_en_s),
    .wr_ptr       (wr_ptr_s),
    .rd_ptr       (rd_ptr_s),
    .count        (count_s),
    .full         (full_s),
    .empty        (empty_s),
    .overflow     (overflow_s)
  );

  assign in_cmd_s = '{saddr:       bus.in_saddr,
                      sdata:       bus.in_sdata,
                      rgb:         bus.in_rgb,
                      compression: bus.in_compression,
                      trigger:     bus.in_trigger};

  // Head fields come straight from the array so a fresh entry is visible one cycle after its push.
  assign head_s              = mem_q[rd_ptr_s];
  assign bus.out_saddr       = head_s.saddr;
  assign bus.out_sdata       = head_s.sdata;
  assign bus.out_rgb         = head_s.rgb;
  assign bus.out_compression = head_s.compression;
  assign bus.out_trigger     = head_s.trigger;
  assign bus.out_valid       = !empty_s;
  assign bus.in_ready        = !full_s;
  assign bus.overflow        = overflow_s;
  assign bus.count           = count_s;

  // Storage write on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push_en_s) begin
      mem_d[wr_ptr_s] = in_cmd_s;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_fifo.sv
// Directed bench for i2c_cmd_fifo with a queue scoreboard of expected command entries.
module tb_i2c_cmd_fifo;
  import i2c_cmd_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;

  i2c_cmd_t exp_q[$];
  logic     exp_ovf;

  i2c_cmd_fifo_if #(.DEPTH(DEPTH)) bus ();

  i2c_cmd_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic i2c_cmd_t mk(input int i);
    i2c_cmd_t c;
    c.saddr       = 8'(8'h40 + i);
    c.sdata       = 16'(16'hA500 ^ (i * 16'h0111));
    c.rgb         = i[0];
    c.compression = 2'(i);
    c.trigger     = i[1];
    return c;
  endfunction

  function automatic i2c_cmd_t head();
    i2c_cmd_t c;
    c.saddr       = bus.out_saddr;
    c.sdata       = bus.out_sdata;
    c.rgb         = bus.out_rgb;
    c.compression = bus.out_compression;
    c.trigger     = bus.out_trigger;
    return c;
  endfunction

  task automatic drive(input i2c_cmd_t c, input logic v, input logic r);
    bus.in_saddr       = c.saddr;
    bus.in_sdata       = c.sdata;
    bus.in_rgb         = c.rgb;
    bus.in_compression = c.compression;
    bus.in_trigger     = c.trigger;
    bus.in_valid       = v;
    bus.out_ready      = r;
  endtask

  // Status checks against the model, taken #1 after the edge.
  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) chk({tag, "_head"}, 32'(head()), 32'(exp_q[0]));
  endtask

  // One clock: update the model from the current inputs, compare popped data, then check state.
  task automatic step(input string tag);
    i2c_cmd_t cur;
    i2c_cmd_t want;
    int       sz;
    sz = exp_q.size();
    cur.saddr = bus.in_saddr; cur.sdata = bus.in_sdata; cur.rgb = bus.in_rgb;
    cur.compression = bus.in_compression; cur.trigger = bus.in_trigger;
    if (bus.flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_ready && sz > 0) begin
        want = exp_q.pop_front();
        chk({tag, "_pop"}, 32'(head()), 32'(want));
      end
      if (bus.in_valid && sz < DEPTH) exp_q.push_back(cur);
      if (bus.in_valid && sz == DEPTH) exp_ovf = 1'b1;
      else if (bus.clr_overflow) exp_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    i2c_cmd_t c0;
    passed  = 0;
    total   = 0;
    exp_ovf = 1'b0;
    reset_n = 1'b0;
    bus.flush = 1'b0;
    bus.clr_overflow = 1'b0;
    drive('0, 1'b0, 1'b0);
    #22;
    check_state("reset");
    chk("reset_head_zero", 32'(head()), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: single push, head visible next cycle, then drain
    c0 = '{saddr: 8'h30, sdata: 16'h1234, rgb: 1'b1, compression: 2'd2, trigger: 1'b0};
    drive(c0, 1'b1, 1'b0);
    step("t1_push");
    drive('0, 1'b0, 1'b0);
    step("t1_hold");
    drive('0, 1'b0, 1'b1);
    step("t1_drain");
    step("t1_empty_ready");

    // 2: fill, overflow on 9th, drain in order
    for (int i = 0; i < 9; i++) begin
      drive(mk(i), 1'b1, 1'b0);
      step("t2_fill");
    end
    drive('0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step("t2_drain");
    drive('0, 1'b0, 1'b0);
    bus.clr_overflow = 1'b1;
    step("t2_clr");
    bus.clr_overflow = 1'b0;

    // 3: steady occupancy 4 with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive(mk(20 + i), 1'b1, 1'b0);
      step("t3_fill");
    end
    for (int i = 0; i < 20; i++) begin
      drive(mk(40 + i), 1'b1, 1'b1);
      step("t3_pp");
    end
    drive('0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("t3_drain");

    // 4: full with push+pop: pop proceeds, push dropped; drop beats clr_overflow
    for (int i = 0; i < 8; i++) begin
      drive(mk(70 + i), 1'b1, 1'b0);
      step("t4_fill");
    end
    drive(mk(99), 1'b1, 1'b1);
    step("t4_pp_full");
    drive(mk(98), 1'b1, 1'b0);
    step("t4_refill");
    bus.clr_overflow = 1'b1;
    drive(mk(97), 1'b1, 1'b0);
    step("t4_drop_vs_clr");
    bus.clr_overflow = 1'b0;
    drive('0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step("t4_drain");

    // 5: flush with concurrent push at count 5; overflow still set from step 4
    for (int i = 0; i < 5; i++) begin
      drive(mk(110 + i), 1'b1, 1'b0);
      step("t5_fill");
    end
    drive(mk(120), 1'b1, 1'b1);
    bus.flush = 1'b1;
    step("t5_flush");
    bus.flush = 1'b0;
    drive('0, 1'b0, 1'b0);
    bus.clr_overflow = 1'b1;
    step("t5_clr");
    bus.clr_overflow = 1'b0;
    drive(mk(121), 1'b1, 1'b0);
    step("t5_after_flush");
    drive('0, 1'b0, 1'b1);
    step("t5_drain");

    // 6: async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      drive(mk(130 + i), 1'b1, 1'b0);
      step("t6_fill");
    end
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_state("t6_async");
    chk("t6_head_zero", 32'(head()), 32'd0);
    drive('0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(mk(140), 1'b1, 1'b0);
    step("t6_push");
    drive('0, 1'b0, 1'b1);
    step("t6_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
